complete_arbiter: RTL
=====================

# complete_arbiter

Collects completion requests from up to `NUM_FU` functional units and issues at most 3 per cycle onto the ROB's three complete ports. The ROB-facing signals are `complete_valid`, `complete_entry`, `precise_state_valid` and `target_pc`. The block sits between the FU output registers and the ROB and applies valid/ready backpressure to FUs that lose arbitration. Grants use rotating priority, so no FU starves, and a branch-recovery flush drops all in-flight work.

## Interface
Parameters:
- `NUM_FU`, 6, number of requesting functional units (valid range 3..16).
- `ROB_IDX_W`, 5, width of a ROB index; equals the codebase's `ROB`.
- `XLEN`, 32, PC width.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `fu_valid`  in  `NUM_FU`  FU i holds a finished instruction.
- `fu_rob_idx`  in  `NUM_FU`×`ROB_IDX_W`  ROB index of FU i's instruction.
- `fu_is_branch`  in  `NUM_FU`  FU i's instruction is a branch.
- `fu_take_branch`  in  `NUM_FU`  the branch resolved as taken.
- `fu_target_pc`  in  `NUM_FU`×`XLEN`  resolved branch target.
- `fu_ready`  out  `NUM_FU`  FU i's request is accepted this cycle (combinational).
- `bp_recover_en`  in  1  branch-recovery flush from retire.
- `complete_valid`  out  3  lane valid, to the ROB.
- `complete_entry`  out  3×`ROB_IDX_W`  lane ROB index.
- `precise_state_valid`  out  3  lane branch-taken flag.
- `target_pc`  out  3×`XLEN`  lane target PC.

## Operation
- Handshake:
  - A request transfers when `fu_valid[i] & fu_ready[i]`.
  - An FU must hold `fu_valid` and its payload stable until accepted.
  - `fu_ready[i]` depends only on the current `fu_valid` vector, `fu_is_branch`, `rr_ptr` and `bp_recover_en`.
- Pick:
  - Scan FU indices `rr_ptr, rr_ptr+1, …` modulo `NUM_FU`.
  - Grant the first ≤3 valid requesters.
  - The 1st grant goes to lane 0, the 2nd to lane 1, the 3rd to lane 2.
- Pointer:
  - If any grant occurred, `rr_ptr` ← (index of the last granted FU + 1) mod `NUM_FU`.
  - Otherwise `rr_ptr` is unchanged.
  - Width is `$clog2(NUM_FU)`; the modulo wrap is explicit, not a natural overflow.
- Payload:
  - The lane registers capture `rob_idx`, `take_branch` and `target_pc` of the granted FU.
  - For non-branch grants, `precise_state_valid=0` and `target_pc=0`.
  - Unused lanes drive 0 on all fields.
- Flush:
  - While `bp_recover_en=1`, `fu_ready` is all 0.
  - Next cycle, all lane registers are 0 and `rr_ptr` is 0.
  - Pending FU requests are not accepted; the FUs clear themselves on the same flush.
- No state machine beyond `rr_ptr` and the 3 lane registers. Duplicate ROB indices across FUs are illegal input and are not checked.

## Timing
- Latency: a request accepted in cycle N appears on the complete ports in cycle N+1 for exactly one cycle.
- Throughput: 3 completions per cycle; a 4th and later requester waits at least one cycle.
- Reset values: `complete_valid=0`, `complete_entry=0`, `precise_state_valid=0`, `target_pc=0`, `rr_ptr=0`.
- `fu_ready=0` whenever `reset=1`.
- Reset has priority over `bp_recover_en`.
- Reset asserted mid-stream clears lanes the following cycle, with no partial issue.
- A request present in the same cycle as `bp_recover_en` is never issued.
- All-FU-valid: exactly 3 grants per cycle, rotating. Every FU is granted within ⌈`NUM_FU`/3⌉ cycles.

## Configuration
- `COMPLETE_ARB_BRANCH_PRIO_EN` defined:
  - The pick runs two passes from `rr_ptr`: first over valid requests with `fu_is_branch=1`, then over the non-branches, filling the remaining lanes.
  - Branch grants occupy the lowest lanes.
  - `rr_ptr` updates from the last grant in scan order of the final pass that granted anything.
- Not defined: single-pass round robin ignoring `fu_is_branch`. `fu_is_branch` is then used only for payload zeroing.

## Structure
- Shared package (`sys_defs.svh`):
  - `COMPLETE_REQ` typedef: `valid`, `rob_idx`, `is_branch`, `take_branch`, `target_pc`.
  - Lane count constant `COMPLETE_LANES=3`.
- One sub-module: `complete_arb_pick`. It is the combinational rotating first-3 picker (request vector plus pointer in; 3 one-hot grants plus lane valids out), instantiated once without the macro and twice with it.
- The top holds `rr_ptr`, the lane registers and the flush logic.

## Test plan
- **Single request:** FU2 valid with `rob_idx`=7, branch, taken, target `0x100` → `fu_ready[2]=1` that cycle. Next cycle lane0 carries `valid=1`, `entry=7`, `psv=1`, `target=0x100`; lanes 1 and 2 are 0. `rr_ptr` becomes 3.
- **All 6 FUs valid for 2 cycles from reset:**
  - Cycle 0 grants FU0–2 and `rr_ptr` becomes 3.
  - Cycle 1 grants FU3–5 and `rr_ptr` becomes 0.
  - Output lane order is FU0, FU1, FU2, then FU3, FU4, FU5.
- **Wrap:** `rr_ptr`=5 with FU0, FU1, FU5 valid → grants FU5, FU0, FU1 in lanes 0, 1, 2; `rr_ptr` becomes 2.
- **Flush:** 4 FUs valid and `bp_recover_en=1` → `fu_ready`=0. Next cycle `complete_valid`=0 and `rr_ptr`=0. The cycle after, with the same requests, grants FU0–2 (lowest indices).
- **Branch priority:**
  - Setup: `rr_ptr`=0; FU0–3 valid; only FU3 is a branch.
  - With `COMPLETE_ARB_BRANCH_PRIO_EN`: grants FU3, FU0, FU1, with FU3 in lane 0.
  - Without the macro: grants FU0, FU1, FU2.
- **Reset mid-stream:** reset asserted while lanes are valid → all outputs 0 the next cycle and `fu_ready`=0 during reset.

Source files
------------

// File: rtl/complete_arbiter_pkg.sv
// Shared types and constants for the completion arbiter slice.
// Widths default to the codebase's ROB index width and PC width.
package complete_arbiter_pkg;

  localparam int ROB            = 5;
  localparam int SYS_XLEN       = 32;
  localparam int COMPLETE_LANES = 3;

  typedef struct packed {
    logic                valid;
    logic [ROB-1:0]      rob_idx;
    logic                is_branch;
    logic                take_branch;
    logic [SYS_XLEN-1:0] target_pc;
  } COMPLETE_REQ;

  // Round-robin pointer advance with an explicit wrap, since NUM_FU is rarely a power of two.
  function automatic int ptrWrap(input int last, input int numFu);
    return (last + 1 >= numFu) ? 0 : last + 1;
  endfunction

endpackage

// File: rtl/complete_arbiter_if.sv
// FU-side request/ready bundle and ROB-side complete ports of the completion arbiter.
// The arbiter uses the slave modport; the FU/ROB environment uses master.
interface complete_arbiter_if
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_FU    = 6,
  parameter int ROB_IDX_W = ROB,
  parameter int XLEN      = SYS_XLEN
);

  logic [NUM_FU-1:0]                         fu_valid;
  logic [NUM_FU-1:0][ROB_IDX_W-1:0]          fu_rob_idx;
  logic [NUM_FU-1:0]                         fu_is_branch;
  logic [NUM_FU-1:0]                         fu_take_branch;
  logic [NUM_FU-1:0][XLEN-1:0]               fu_target_pc;
  logic [NUM_FU-1:0]                         fu_ready;

  logic [COMPLETE_LANES-1:0]                 complete_valid;
  logic [COMPLETE_LANES-1:0][ROB_IDX_W-1:0]  complete_entry;
  logic [COMPLETE_LANES-1:0]                 precise_state_valid;
  logic [COMPLETE_LANES-1:0][XLEN-1:0]       target_pc;

  modport master (
    output fu_valid, fu_rob_idx, fu_is_branch, fu_take_branch, fu_target_pc,
    input  fu_ready,
    input  complete_valid, complete_entry, precise_state_valid, target_pc
  );

  modport slave (
    input  fu_valid, fu_rob_idx, fu_is_branch, fu_take_branch, fu_target_pc,
    output fu_ready,
    output complete_valid, complete_entry, precise_state_valid, target_pc
  );

endinterface

// File: rtl/complete_arb_pick.sv
// Combinational rotating first-3 picker: scans requests from i_ptr upward modulo NUM_FU
// and hands the first three hits to lanes 0, 1, 2 as one-hot grants.
module complete_arb_pick
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = 6,
  parameter int PTR_W  = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]                     i_req,
  input  logic [PTR_W-1:0]                      i_ptr,
  output logic [COMPLETE_LANES-1:0][NUM_FU-1:0] o_grant,
  output logic [COMPLETE_LANES-1:0]             o_laneValid
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic [1:0]       w_cnt;

  always_comb begin
    o_grant     = '0;
    o_laneValid = '0;
    w_sum       = '0;
    w_idx       = '0;
    w_cnt       = 2'd0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_FU)) w_sum = w_sum - (PTR_W+1)'(NUM_FU);
      w_idx = w_sum[PTR_W-1:0];
      if (i_req[w_idx] && (w_cnt != 2'd3)) begin
        o_grant[w_cnt][w_idx] = 1'b1;
        o_laneValid[w_cnt]    = 1'b1;
        w_cnt                 = w_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Completion arbiter: issues up to 3 FU completions per cycle to the ROB with rotating priority.
// Define COMPLETE_ARB_BRANCH_PRIO_EN to let branches win lanes ahead of other completions.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_FU    = 6,
  parameter int ROB_IDX_W = ROB,
  parameter int XLEN      = SYS_XLEN
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_bp_recover_en,
  complete_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [PTR_W-1:0]                         r_rrPtr;
  COMPLETE_REQ [COMPLETE_LANES-1:0]         r_lane;
  COMPLETE_REQ [COMPLETE_LANES-1:0]         w_next;
  logic [COMPLETE_LANES-1:0][NUM_FU-1:0]    w_grant;
  logic [COMPLETE_LANES-1:0]                w_laneValid;
  logic [PTR_W-1:0]                         w_lastIdx;
  logic                                     w_flush;

  assign w_flush = reset | i_bp_recover_en;

`ifdef COMPLETE_ARB_BRANCH_PRIO_EN
  logic [COMPLETE_LANES-1:0][NUM_FU-1:0] w_brGrant;
  logic [COMPLETE_LANES-1:0][NUM_FU-1:0] w_nbGrant;
  logic [COMPLETE_LANES-1:0]             w_brValid;
  logic [COMPLETE_LANES-1:0]             w_nbValid;
  logic [1:0]                            w_numBr;
  logic [1:0]                            w_src;

  complete_arb_pick #(.NUM_FU(NUM_FU), .PTR_W(PTR_W)) u_pickBranch (
    .i_req       (bus.fu_valid & bus.fu_is_branch),
    .i_ptr       (r_rrPtr),
    .o_grant     (w_brGrant),
    .o_laneValid (w_brValid)
  );

  complete_arb_pick #(.NUM_FU(NUM_FU), .PTR_W(PTR_W)) u_pickOther (
    .i_req       (bus.fu_valid & ~bus.fu_is_branch),
    .i_ptr       (r_rrPtr),
    .o_grant     (w_nbGrant),
    .o_laneValid (w_nbValid)
  );

  // Branch grants fill lanes from 0; non-branch grants slide up into whatever is left.
  always_comb begin
    w_grant     = '0;
    w_laneValid = '0;
    w_src       = 2'd0;
    w_numBr     = 2'(w_brValid[0]) + 2'(w_brValid[1]) + 2'(w_brValid[2]);
    for (int l = 0; l < COMPLETE_LANES; l++) begin
      if (w_brValid[l]) begin
        w_grant[l]     = w_brGrant[l];
        w_laneValid[l] = 1'b1;
      end else begin
        w_src          = 2'(l) - w_numBr;
        w_grant[l]     = w_nbGrant[w_src];
        w_laneValid[l] = w_nbValid[w_src];
      end
    end
  end
`else
  complete_arb_pick #(.NUM_FU(NUM_FU), .PTR_W(PTR_W)) u_pick (
    .i_req       (bus.fu_valid),
    .i_ptr       (r_rrPtr),
    .o_grant     (w_grant),
    .o_laneValid (w_laneValid)
  );
`endif

  // The highest occupied lane always holds the last grant of the last pass that granted.
  always_comb begin
    w_lastIdx = '0;
    for (int l = 0; l < COMPLETE_LANES; l++)
      if (w_laneValid[l])
        for (int f = 0; f < NUM_FU; f++)
          if (w_grant[l][f]) w_lastIdx = PTR_W'(f);
  end

  always_comb begin
    bus.fu_ready = '0;
    if (!w_flush)
      for (int l = 0; l < COMPLETE_LANES; l++) bus.fu_ready = bus.fu_ready | w_grant[l];
  end

  always_comb begin
    w_next = '0;
    for (int l = 0; l < COMPLETE_LANES; l++)
      for (int f = 0; f < NUM_FU; f++)
        if (w_grant[l][f]) begin
          w_next[l].valid       = 1'b1;
          w_next[l].rob_idx     = bus.fu_rob_idx[f];
          w_next[l].is_branch   = bus.fu_is_branch[f];
          w_next[l].take_branch = bus.fu_take_branch[f];
          w_next[l].target_pc   = bus.fu_is_branch[f] ? bus.fu_target_pc[f] : '0;
        end
  end

  // Lanes hold a grant for exactly one cycle; reset and recovery both wipe them.
  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_rrPtr <= '0;
      r_lane  <= '0;
    end else begin
      r_lane <= w_next;
      if (w_laneValid[0]) r_rrPtr <= PTR_W'(ptrWrap(int'(w_lastIdx), NUM_FU));
    end
  end

  always_comb begin
    bus.complete_valid      = '0;
    bus.complete_entry      = '0;
    bus.precise_state_valid = '0;
    bus.target_pc           = '0;
    for (int l = 0; l < COMPLETE_LANES; l++) begin
      bus.complete_valid[l]      = r_lane[l].valid;
      bus.complete_entry[l]      = r_lane[l].rob_idx;
      bus.precise_state_valid[l] = r_lane[l].take_branch & r_lane[l].is_branch;
      bus.target_pc[l]           = r_lane[l].target_pc;
    end
  end

endmodule
